// File: rtl/prince_sop_pkg.sv
// Shared definitions for the final sum-of-products stage of the 2-share PRINCE S-box:
// monomial indices, the ANF coefficient masks of each S-box output bit and the
// stage-1 payload type.
package prince_sop_pkg;

   localparam int unsigned NSH   = 2;
   localparam int unsigned NMONO = 14;
   localparam int unsigned NOUT  = 4;
   localparam int unsigned NRND  = 5;

   // Monomial positions inside mono_sh0/mono_sh1 (and inside an ANF mask)
   localparam int unsigned MONO_X0   = 0;
   localparam int unsigned MONO_X1   = 1;
   localparam int unsigned MONO_X2   = 2;
   localparam int unsigned MONO_X3   = 3;
   localparam int unsigned MONO_X01  = 4;
   localparam int unsigned MONO_X02  = 5;
   localparam int unsigned MONO_X03  = 6;
   localparam int unsigned MONO_X12  = 7;
   localparam int unsigned MONO_X13  = 8;
   localparam int unsigned MONO_X23  = 9;
   localparam int unsigned MONO_X012 = 10;
   localparam int unsigned MONO_X013 = 11;
   localparam int unsigned MONO_X023 = 12;
   localparam int unsigned MONO_X123 = 13;
   localparam int unsigned QUAD_IDX  = 14;
   localparam int unsigned CONST_IDX = 15;

   // S-box table, nibble i holds S[i]
   localparam logic [63:0] SBOX_TABLE = 64'h4D5E_0876_19CA_23FB;

   // Stage-1 payload: both shares of the monomial vector
   typedef struct packed {
      logic [NMONO-1:0] sh1;
      logic [NMONO-1:0] sh0;
   } mono_pair_t;

   // Position of the monomial whose variable set is u (bit i set = x_i present)
   function automatic logic [3:0] anf_pos(input logic [3:0] u);
      logic [3:0] pos;
      case (u)
         4'h1:    pos = 4'(MONO_X0);
         4'h2:    pos = 4'(MONO_X1);
         4'h4:    pos = 4'(MONO_X2);
         4'h8:    pos = 4'(MONO_X3);
         4'h3:    pos = 4'(MONO_X01);
         4'h5:    pos = 4'(MONO_X02);
         4'h9:    pos = 4'(MONO_X03);
         4'h6:    pos = 4'(MONO_X12);
         4'hA:    pos = 4'(MONO_X13);
         4'hC:    pos = 4'(MONO_X23);
         4'h7:    pos = 4'(MONO_X012);
         4'hB:    pos = 4'(MONO_X013);
         4'hD:    pos = 4'(MONO_X023);
         4'hE:    pos = 4'(MONO_X123);
         4'hF:    pos = 4'(QUAD_IDX);
         default: pos = 4'(CONST_IDX);
      endcase
      return pos;
   endfunction

   // Moebius transform of output bit k: coefficient of monomial u is the XOR of S[x][k]
   // over every x whose variables are a subset of u
   function automatic logic [15:0] anf_mask(input int unsigned k);
      logic [15:0] mask;
      logic        c;
      mask = '0;
      for (int u = 0; u < 16; u++) begin
         c = 1'b0;
         for (int x = 0; x < 16; x++) begin
            if (((x & ~u) & 15) == 0) c = c ^ SBOX_TABLE[6'(4 * x + int'(k))];
         end
         mask[anf_pos(4'(u))] = c;
      end
      return mask;
   endfunction

   localparam logic [15:0] ANF_Y [0:3] = '{anf_mask(0), anf_mask(1), anf_mask(2), anf_mask(3)};

endpackage

// File: rtl/dom_and_2sh.sv
// Two-share DOM AND gate. The four partial products (cross terms refreshed with r)
// are registered on en; recombination happens only after the register.
// Ports: clk/rst (sync, active-high), en (capture), a_sh0/a_sh1, b_sh0/b_sh1 (shared
// operands), r (fresh bit), q_sh0_c/q_sh1_c (shares of a&b, from registered partials).
module dom_and_2sh (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic a_sh0,
   input  logic a_sh1,
   input  logic b_sh0,
   input  logic b_sh1,
   input  logic r,
   output logic q_sh0_c,
   output logic q_sh1_c
);

   logic p00_q, p01_q, p11_q, p10_q;
   logic p00_d, p01_d, p11_d, p10_d;

   // Partial products; each share domain only sees one cross term, masked by r
   always_comb begin
      p00_d = p00_q;
      p01_d = p01_q;
      p11_d = p11_q;
      p10_d = p10_q;
      if (en) begin
         p00_d = a_sh0 & b_sh0;
         p01_d = (a_sh0 & b_sh1) ^ r;
         p11_d = a_sh1 & b_sh1;
         p10_d = (a_sh1 & b_sh0) ^ r;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p00_q <= 1'b0;
         p01_q <= 1'b0;
         p11_q <= 1'b0;
         p10_q <= 1'b0;
      end else begin
         p00_q <= p00_d;
         p01_q <= p01_d;
         p11_q <= p11_d;
         p10_q <= p10_d;
      end
   end

   // Recombination behind the glitch barrier
   assign q_sh0_c = p00_q ^ p01_q;
   assign q_sh1_c = p11_q ^ p10_q;

endmodule

// File: rtl/prince_sbox_sop_final.sv
// Final stage of the 2-share PRINCE S-box: builds x0123 = x012 & x3 with a DOM AND and
// forms the four shared output bits as ANF XOR sums. Two-stage valid/ready pipeline.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + mono_sh0/mono_sh1 (shared
// monomials m[13:0]) + rnd[4:0] (fresh randomness); out_valid/out_ready + y_sh0/y_sh1.
// REFRESH=1 XORs rnd[4:1] into both output shares.
module prince_sbox_sop_final
   import prince_sop_pkg::*;
#(
   parameter bit REFRESH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NMONO-1:0] mono_sh0,
   input  logic [NMONO-1:0] mono_sh1,
   input  logic [NRND-1:0]  rnd,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NOUT-1:0]  y_sh0,
   output logic [NOUT-1:0]  y_sh1
);

   logic            v1_q, v1_d, v2_q, v2_d;
   mono_pair_t      mono_q, mono_d;
   logic [NOUT-1:0] r_q, r_d;
   logic [NOUT-1:0] y0_q, y0_d, y1_q, y1_d;
   logic            accept_c, advance_c;
   logic            q0_c, q1_c;
   logic [NOUT-1:0] ys0_c, ys1_c;

   // Quartic monomial x0123 = x012 & x3
   dom_and_2sh u_dom (
      .clk     (clk),
      .rst     (rst),
      .en      (accept_c),
      .a_sh0   (mono_sh0[MONO_X012]),
      .a_sh1   (mono_sh1[MONO_X012]),
      .b_sh0   (mono_sh0[MONO_X3]),
      .b_sh1   (mono_sh1[MONO_X3]),
      .r       (rnd[0]),
      .q_sh0_c (q0_c),
      .q_sh1_c (q1_c)
   );

   // Handshake, stage control and the per-share ANF sums
   always_comb begin
      in_ready  = !v1_q || !v2_q || out_ready;
      accept_c  = in_valid && in_ready;
      advance_c = v1_q && (!v2_q || out_ready);

      v1_d   = v1_q;
      v2_d   = v2_q;
      mono_d = mono_q;
      r_d    = r_q;
      y0_d   = y0_q;
      y1_d   = y1_q;
      ys0_c  = '0;
      ys1_c  = '0;

      // Each share is summed independently; only share 0 carries the constant term
      for (int k = 0; k < int'(NOUT); k++) begin
         ys0_c[k] = (^(ANF_Y[k][NMONO-1:0] & mono_q.sh0)) ^ (ANF_Y[k][QUAD_IDX] & q0_c)
                    ^ ANF_Y[k][CONST_IDX] ^ (REFRESH & r_q[k]);
         ys1_c[k] = (^(ANF_Y[k][NMONO-1:0] & mono_q.sh1)) ^ (ANF_Y[k][QUAD_IDX] & q1_c)
                    ^ (REFRESH & r_q[k]);
      end

      if (accept_c) begin
         v1_d       = 1'b1;
         mono_d.sh0 = mono_sh0;
         mono_d.sh1 = mono_sh1;
         r_d        = rnd[NRND-1:1];
      end else if (advance_c) begin
         v1_d = 1'b0;
      end

      if (advance_c) begin
         v2_d = 1'b1;
         y0_d = ys0_c;
         y1_d = ys1_c;
      end else if (out_ready) begin
         v2_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         mono_q <= '0;
         r_q    <= '0;
         y0_q   <= '0;
         y1_q   <= '0;
      end else begin
         v1_q   <= v1_d;
         v2_q   <= v2_d;
         mono_q <= mono_d;
         r_q    <= r_d;
         y0_q   <= y0_d;
         y1_q   <= y1_d;
      end
   end

   assign out_valid = v2_q;
   assign y_sh0     = y0_q;
   assign y_sh1     = y1_q;

endmodule

// File: tb/tb_prince_sbox_sop_final.sv
// Scoreboard bench for prince_sbox_sop_final: the driver pushes the expected output of
// every accepted item; a negedge monitor pops and compares on every output transfer.
module tb_prince_sbox_sop_final;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready;
   logic [13:0] mono_sh0, mono_sh1;
   logic [4:0]  rnd;
   logic [3:0]  y_sh0, y_sh1;

   always #5 clk = ~clk;

   prince_sbox_sop_final #(.REFRESH(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mono_sh0  (mono_sh0),
      .mono_sh1  (mono_sh1),
      .rnd       (rnd),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y_sh0     (y_sh0),
      .y_sh1     (y_sh1)
   );

   typedef struct {
      bit          exact;
      logic [3:0]  e0;
      logic [3:0]  e1;
      bit          chk_lat;
      int unsigned acc_cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;
   bit          cur_exact, cur_lat;
   logic [3:0]  cur_e0, cur_e1;
   logic [3:0]  s_tab [16];
   logic [3:0]  held0, held1;
   bit          held_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [13:0] monomials(input logic [3:0] x);
      logic [13:0] m;
      m[0]  = x[0];
      m[1]  = x[1];
      m[2]  = x[2];
      m[3]  = x[3];
      m[4]  = x[0] & x[1];
      m[5]  = x[0] & x[2];
      m[6]  = x[0] & x[3];
      m[7]  = x[1] & x[2];
      m[8]  = x[1] & x[3];
      m[9]  = x[2] & x[3];
      m[10] = x[0] & x[1] & x[2];
      m[11] = x[0] & x[1] & x[3];
      m[12] = x[0] & x[2] & x[3];
      m[13] = x[1] & x[2] & x[3];
      return m;
   endfunction

   // Monitor + scoreboard: check transfers first, then record this cycle's accept
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         held_v = 1'b0;
      end else begin
         if (out_valid && !out_ready) begin
            if (held_v) begin
               checks++;
               if (y_sh0 !== held0 || y_sh1 !== held1) begin
                  errors++;
                  $display("FAIL stall_hold y_sh0=%h y_sh1=%h required %h %h", y_sh0, y_sh1, held0, held1);
               end
            end
            held0  = y_sh0;
            held1  = y_sh1;
            held_v = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output y_sh0=%h y_sh1=%h required no output", y_sh0, y_sh1);
            end else begin
               e = sb.pop_front();
               if (e.exact) begin
                  if (y_sh0 !== e.e0 || y_sh1 !== e.e1) begin
                     errors++;
                     $display("FAIL exact_out y_sh0=%h y_sh1=%h required %h %h", y_sh0, y_sh1, e.e0, e.e1);
                  end
               end else if ((y_sh0 ^ y_sh1) !== e.e0) begin
                  errors++;
                  $display("FAIL unshared_out y=%h required %h", y_sh0 ^ y_sh1, e.e0);
               end
               if (e.chk_lat) begin
                  checks++;
                  if (cyc - e.acc_cyc != 2) begin
                     errors++;
                     $display("FAIL latency got %0d required 2", cyc - e.acc_cyc);
                  end
               end
            end
         end
         if (in_valid && in_ready)
            sb.push_back('{cur_exact, cur_e0, cur_e1, cur_lat, cyc});
      end
   end

   task automatic drive(input logic [3:0] x, input logic [13:0] s0, input logic [4:0] r,
                        input bit exact, input logic [3:0] e0, input logic [3:0] e1, input bit lat);
      mono_sh0  = s0;
      mono_sh1  = monomials(x) ^ s0;
      rnd       = r;
      cur_exact = exact;
      cur_e0    = e0;
      cur_e1    = e1;
      cur_lat   = lat;
      in_valid  = 1'b1;
   endtask

   // Returns the number of cycles the item was presented before it was taken
   task automatic wait_accept(input string tag, output int n);
      bit acc;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready;
         n++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL %s accept_timeout in_ready=%b required 1", tag, in_ready);
      end
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      end
   endtask

   task automatic check_idle(input string tag);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_flags out_valid=%b in_ready=%b required 0 1", tag, out_valid, in_ready);
      end
      checks++;
      if (y_sh0 !== 4'h0 || y_sh1 !== 4'h0) begin
         errors++;
         $display("FAIL %s_data y_sh0=%h y_sh1=%h required 0 0", tag, y_sh0, y_sh1);
      end
   endtask

   initial begin
      int         n;
      logic [3:0] xs [3];
      logic [3:0] es [3];
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mono_sh0  = '0;
      mono_sh1  = '0;
      rnd       = '0;
      cur_exact = 1'b0;
      cur_lat   = 1'b0;
      cur_e0    = '0;
      cur_e1    = '0;
      s_tab = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1;

      // 1: unmasked, rnd=0 -> y_sh0 = S[x], y_sh1 = 0
      xs = '{4'h0, 4'h5, 4'hF};
      es = '{4'hB, 4'hC, 4'h4};
      for (int i = 0; i < 3; i++) begin
         drive(xs[i], monomials(xs[i]), 5'h00, 1'b1, es[i], 4'h0, 1'b0);
         wait_accept("unmasked", n);
      end
      drain();

      // 2: random share split and randomness, all x
      for (int x = 0; x < 16; x++) begin
         drive(4'(x), 14'($urandom), 5'($urandom), 1'b0, s_tab[x], 4'h0, 1'b0);
         wait_accept("random_split", n);
      end
      drain();

      // 3: back-to-back stream, latency 2, no backpressure
      for (int x = 0; x < 16; x++) begin
         drive(4'(x), 14'($urandom), 5'($urandom), 1'b0, s_tab[x], 4'h0, 1'b1);
         wait_accept("stream", n);
         checks++;
         if (n != 1) begin
            errors++;
            $display("FAIL stream_in_ready waited %0d cycles required 1", n);
         end
      end
      drain();

      // 4: backpressure with x=1,2,3 unmasked
      out_ready = 1'b0;
      drive(4'h1, monomials(4'h1), 5'h00, 1'b1, 4'hF, 4'h0, 1'b0);
      wait_accept("stall_a", n);
      drive(4'h2, monomials(4'h2), 5'h00, 1'b1, 4'h3, 4'h0, 1'b0);
      wait_accept("stall_b", n);
      drive(4'h3, monomials(4'h3), 5'h00, 1'b1, 4'h2, 4'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || y_sh0 !== 4'hF) begin
            errors++;
            $display("FAIL stall_full in_ready=%b out_valid=%b y_sh0=%h required 0 1 F",
                     in_ready, out_valid, y_sh0);
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      wait_accept("stall_c", n);
      drain();

      // 5: reset with both stages full
      out_ready = 1'b0;
      drive(4'h7, monomials(4'h7), 5'h00, 1'b1, 4'h1, 4'h0, 1'b0);
      wait_accept("flush_a", n);
      drive(4'h8, monomials(4'h8), 5'h00, 1'b1, 4'h6, 4'h0, 1'b0);
      wait_accept("flush_b", n);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle("flush");
      out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;

      // 6: output refresh, x=3 fixed, rnd[4:1] swept
      for (int r = 0; r < 16; r++) begin
         drive(4'h3, monomials(4'h3), {4'(r), 1'b0}, 1'b1, 4'h2 ^ 4'(r), 4'(r), 1'b0);
         wait_accept("refresh", n);
      end
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
